// File: rtl/ls7404_arbiter_pkg.sv
// ls7404_arbiter shared types and sizes.
// Optional op counter: INV_ARB_COUNT_EN.
package ls7404_arbiter_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    EXEC = 2'd1,
    RESP = 2'd2
  } state_e;

  localparam int INV_W    = 6;
  localparam int CNT_W    = 16;
  localparam int NREQ_MAX = 8;

  // Saturating increment for the op counter.
  function automatic logic [CNT_W-1:0] sat_inc(
    input logic [CNT_W-1:0] v
  );
    return (v == '1) ? v : v + CNT_W'(1);
  endfunction

endpackage

// File: rtl/ls7404_arbiter_if.sv
// Requester-side bundle of the ls7404 arbiter.
// op_count present only with INV_ARB_COUNT_EN.
interface ls7404_arbiter_if
  import ls7404_arbiter_pkg::*;
#(
  parameter int NREQ = 4
) ();

  logic [NREQ-1:0]       req;
  logic [INV_W*NREQ-1:0] operand;
  logic [NREQ-1:0]       grant;
  logic [NREQ-1:0]       done;
  logic [INV_W-1:0]      result;
  logic                  busy;
`ifdef INV_ARB_COUNT_EN
  logic [CNT_W-1:0]      op_count;
`endif

`ifdef INV_ARB_COUNT_EN
  modport master (
    output req, operand,
    input  grant, done, result, busy, op_count
  );

  modport slave (
    input  req, operand,
    output grant, done, result, busy, op_count
  );
`else
  modport master (
    output req, operand,
    input  grant, done, result, busy
  );

  modport slave (
    input  req, operand,
    output grant, done, result, busy
  );
`endif

endinterface

// File: rtl/ls7404.sv
// ls7404 hex inverter chip model.
// Six independent NOT gates.
module ls7404 (
  input  logic [5:0] a,
  output logic [5:0] y
);

  assign y = ~a;

endmodule

// File: rtl/ls7404_rr_pick.sv
// Round-robin search: first req at or
// after ptr, wrapping modulo NREQ.
module ls7404_rr_pick #(
  parameter int NREQ = 4,
  parameter int PW   = 2
) (
  input  logic [NREQ-1:0] req_i,
  input  logic [PW-1:0]   ptr_i,
  output logic            found_o,
  output logic [PW-1:0]   idx_o
);

  logic [2*NREQ-1:0] dbl;
  logic [NREQ-1:0]   rot;
  logic [PW:0]       sum;

  // Rotate so bit 0 is the ptr slot.
  assign dbl = {req_i, req_i} >> ptr_i;
  assign rot = dbl[NREQ-1:0];

  assign found_o = |req_i;

  // Lowest rotated slot wins; map back.
  always_comb begin
    idx_o = '0;
    sum   = '0;
    for (int k = NREQ - 1; k >= 0; k--) begin
      if (rot[k]) begin
        sum = {1'b0, ptr_i} + (PW+1)'(k);
        if (sum >= (PW+1)'(NREQ))
          sum = sum - (PW+1)'(NREQ);
        idx_o = sum[PW-1:0];
      end
    end
  end

endmodule

// File: rtl/ls7404_arbiter.sv
// Round-robin sequencer sharing one ls7404.
// INV_ARB_COUNT_EN adds the op_count counter.
module ls7404_arbiter
  import ls7404_arbiter_pkg::*;
#(
  parameter int NREQ = 4
) (
  input logic            clk,
  input logic            rst,
  ls7404_arbiter_if.slave bus
);

  localparam int PW =
    (NREQ > 1) ? $clog2(NREQ) : 1;

  localparam logic [1:0] S_IDLE = 2'(IDLE);
  localparam logic [1:0] S_EXEC = 2'(EXEC);
  localparam logic [1:0] S_RESP = 2'(RESP);

  logic [1:0]       state_q, state_d;
  logic [NREQ-1:0]  grant_q, grant_d;
  logic [NREQ-1:0]  done_q, done_d;
  logic [INV_W-1:0] a_q, a_d;
  logic [INV_W-1:0] result_q, result_d;
  logic [PW-1:0]    ptr_q, ptr_d;
  logic [PW-1:0]    idx_q, idx_d;

  logic             pick_found;
  logic [PW-1:0]    pick_idx;
  logic [INV_W-1:0] inv_y;
  logic [INV_W-1:0] ops [NREQ];
  logic [PW-1:0]    idx_nxt;

  // Unpack the flat operand bus per lane.
  always_comb begin
    for (int i = 0; i < NREQ; i++)
      ops[i] = bus.operand[i*INV_W +: INV_W];
  end

  ls7404_rr_pick #(
    .NREQ (NREQ),
    .PW   (PW)
  ) u_pick (
    .req_i   (bus.req),
    .ptr_i   (ptr_q),
    .found_o (pick_found),
    .idx_o   (pick_idx)
  );

  ls7404 u_inv (
    .a (a_q),
    .y (inv_y)
  );

  // Pointer after the served lane; NREQ=1 stays 0.
  assign idx_nxt =
    (idx_q == PW'(NREQ - 1)) ? '0
                             : idx_q + PW'(1);

  // Next-state and datapath control.
  always_comb begin
    state_d  = state_q;
    grant_d  = grant_q;
    done_d   = done_q;
    a_d      = a_q;
    result_d = result_q;
    ptr_d    = ptr_q;
    idx_d    = idx_q;
    unique case (state_q)
      S_IDLE: begin
        if (pick_found) begin
          idx_d = pick_idx;
          a_d   = ops[pick_idx];
          for (int i = 0; i < NREQ; i++)
            grant_d[i] = (pick_idx == PW'(i));
          state_d = S_EXEC;
        end
      end
      S_EXEC: begin
        result_d = inv_y;
        done_d   = grant_q;
        state_d  = S_RESP;
      end
      S_RESP: begin
        done_d  = '0;
        grant_d = '0;
        ptr_d   = idx_nxt;
        state_d = S_IDLE;
      end
      default: begin
        state_d = S_IDLE;
        grant_d = '0;
        done_d  = '0;
      end
    endcase
  end

  // Sequencer state with synchronous reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= S_IDLE;
      grant_q  <= '0;
      done_q   <= '0;
      a_q      <= '0;
      result_q <= '0;
      ptr_q    <= '0;
      idx_q    <= '0;
    end else begin
      state_q  <= state_d;
      grant_q  <= grant_d;
      done_q   <= done_d;
      a_q      <= a_d;
      result_q <= result_d;
      ptr_q    <= ptr_d;
      idx_q    <= idx_d;
    end
  end

  assign bus.grant  = grant_q;
  assign bus.done   = done_q;
  assign bus.result = result_q;
  assign bus.busy   = (state_q != S_IDLE);

`ifdef INV_ARB_COUNT_EN
  logic [CNT_W-1:0] cnt_q, cnt_d;

  // Count completions, saturating.
  always_comb begin
    cnt_d = cnt_q;
    if (state_q == S_EXEC)
      cnt_d = sat_inc(cnt_q);
  end

  // Completed-operation counter register.
  always_ff @(posedge clk) begin
    if (rst) cnt_q <= '0;
    else     cnt_q <= cnt_d;
  end

  assign bus.op_count = cnt_q;
`endif

  // Grant is one-hot; done only on granted lane.
  a_grant_oh : assert property (
    @(posedge clk) disable iff (rst)
    $onehot0(grant_q)
  );

  a_done_in_grant : assert property (
    @(posedge clk) disable iff (rst)
    (done_q & ~grant_q) == '0
  );

endmodule

// File: doc/ls7404_arbiter.md
# ls7404_arbiter

Round-robin arbiter and sequencer that shares one 6-bit hex-inverter datapath (an `ls7404` instance) between up to NREQ requesters. Each requester presents a 6-bit operand with a level request. The block grants one requester at a time, latches its operand onto the inverter input, captures the inverted result into a register, and returns a one-cycle completion pulse. It sits between the CPU-side units that need bitwise NOT and the single shared inverter chip model.

## Interface
- NREQ, default 4: number of requesters, 1..8.
- clk  in  1  clock; all state updates on rising edge.
- rst  in  1  synchronous reset, active-high.
- req  in  NREQ  level request per requester; sampled only in IDLE.
- operand  in  6*NREQ  requester i's operand is bits [6i+5:6i].
- grant  out  NREQ  one-hot; high for requester being served, EXEC through RESP.
- done  out  NREQ  one-hot one-cycle completion pulse.
- result  out  6  registered inverter output; held until next capture.
- busy  out  1  high whenever state ≠ IDLE.
- op_count  out  16  completed-operation counter; present only with INV_ARB_COUNT_EN.

## Operation
- States: IDLE, EXEC, RESP.
- Reset values: state = IDLE, grant = 0, done = 0, result = 6'b000000, busy = 0, ptr = 0, op_count = 0.
- **IDLE**
  - If req == 0, stay in IDLE.
  - Otherwise pick the first asserted req at or after ptr, wrapping modulo NREQ.
  - Latch its index into idx, set grant[idx], and register its operand into a_reg, which drives the inverter input.
  - Next state is EXEC.
- **EXEC**
  - result <= inverter output (~a_reg).
  - Set done[idx].
  - Next state is RESP.
- **RESP**
  - Clear done and grant.
  - ptr <= (idx+1) mod NREQ.
  - Next state is IDLE.
- req is ignored outside IDLE.
- A requester that drops req after being granted still receives its done pulse, because its operand is already latched.
- A requester must drop req in the cycle done is high; otherwise it is re-served in a later round as a new operation.
- Operand changes after the grant edge have no effect.
- Simultaneous requests: the lowest index at or after ptr wins; all others wait with req held.
- NREQ = 1: ptr is a constant 0; the same state sequence applies.
- Reset asserted in any state aborts the operation: no done is issued, all outputs take their reset values, and ptr returns to 0.

## Timing
- Grant edge E0: req sampled in IDLE; grant and a_reg update.
- Edge E1: result is valid and done is high for exactly one cycle (E1 to E2).
- Edge E2: grant and done drop.
- Edge E3: earliest next request sample.
- Throughput: one operation per 3 cycles; request-to-done latency is 2 edges.
- result stays stable from E1 until the next operation's E1.
- A requester is serviced within at most 3·NREQ cycles of asserting req while others continuously request.

## Configuration
- INV_ARB_COUNT_EN defined:
  - op_count port exists.
  - op_count increments on each EXEC→RESP transition and saturates at 16'hFFFF.
  - op_count resets to 0.
- Undefined: the op_count port and its counter logic are absent; all other behaviour is identical.

## Structure
- Package `ls7404_arbiter_pkg` holds:
  - state enum (IDLE, EXEC, RESP);
  - INV_W = 6;
  - CNT_W = 16;
  - NREQ_MAX = 8.
- Sub-module `ls7404_rr_pick` (combinational): inputs req and ptr; outputs found and idx. This is the round-robin search.
- Existing `ls7404` is instantiated unchanged as the datapath; its a input comes from a_reg and its y output feeds the result register.

## Test plan
- Reset: hold rst 2 cycles with req = 4'b1111 → grant, done, result and busy are 0; no grant occurs while rst is high.
- Single request: req0 with operand 6'b001010 → grant = 4'b0001 at E0; done = 4'b0001 and result = 6'b110101 at E1; busy low after E2.
- Four simultaneous requests from reset with operands 6'b000000, 6'b111111, 6'b101010, 6'b010101, each req dropped on its done → service order 0,1,2,3 at 3-cycle spacing; results 6'b111111, 6'b000000, 6'b010101, 6'b101010.
- Fairness: req0 and req2 held high continuously for 12 cycles → grants alternate 0,2,0,2; each done pulse is exactly one cycle.
- Reset during EXEC: assert rst while state = EXEC → no done pulse and result = 0; next request with req1 and req3 both high is granted to req1 (ptr = 0).
- With INV_ARB_COUNT_EN: complete 5 operations → op_count = 5; after a reset, op_count = 0. Without the macro, the build has no op_count port.
